// File: rtl/led_scan_ctrl.sv
// Scans an 8-digit hex display: steps through enabled digits, one nibble/select pair per dwell period.
// Latency: outputs are registered state; a new value shows at the next frame boundary.
// Backpressure: none; iLoad is always accepted and the last load before a boundary wins.
module led_scan_ctrl #(
    parameter int DIV = 50000
) (
    input  logic        iClk,
    input  logic        iRst_n,
    input  logic [31:0] iData,
    input  logic        iLoad,
    input  logic [7:0]  iMask,
    output logic [3:0]  oNibble,
    output logic [2:0]  oSel,
    output logic        oBlank,
    output logic        oPending,
    output logic        oFrame
);

    localparam int PW = $clog2(DIV);
    localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

    typedef enum logic {RUN, IDLE} state_t;

    state_t        state;
    state_t        stateNxt;
    logic [PW-1:0] presc;
    logic [31:0]   pend;
    logic          pendV;
    logic [31:0]   act;
    logic [7:0]    maskA;
    logic [2:0]    digit;
    logic [2:0]    digitNxt;
    logic          boundary;
    logic          tick;
    logic [7:0]    higher;

    function automatic logic [2:0] lowestSet(input logic [7:0] m);
        lowestSet = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (m[k]) lowestSet = 3'(k);
        end
    endfunction

    assign tick   = (presc == PMAX);
    // Enabled digits strictly above the current one; empty means the frame ends here.
    assign higher = maskA & ~((8'd2 << digit) - 8'd1);

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state <= RUN;
        end else begin
            state <= stateNxt;
        end
    end

    always_comb begin
        stateNxt = state;
        digitNxt = digit;
        boundary = 1'b0;
        case (state)
            RUN: begin
                if (tick) begin
                    if (higher != 8'd0) begin
                        digitNxt = lowestSet(higher);
                    end else begin
                        boundary = 1'b1;
                        if (iMask != 8'd0) begin
                            digitNxt = lowestSet(iMask);
                        end else begin
                            digitNxt = 3'd0;
                            stateNxt = IDLE;
                        end
                    end
                end
            end
            IDLE: begin
                if (tick && iMask != 8'd0) begin
                    boundary = 1'b1;
                    digitNxt = lowestSet(iMask);
                    stateNxt = RUN;
                end
            end
            default: stateNxt = RUN;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            presc  <= '0;
            pend   <= 32'd0;
            pendV  <= 1'b0;
            act    <= 32'd0;
            maskA  <= 8'hFF;
            digit  <= 3'd0;
            oFrame <= 1'b0;
        end else begin
            presc  <= tick ? '0 : presc + PW'(1);
            digit  <= digitNxt;
            oFrame <= boundary;
            if (boundary) begin
                maskA <= iMask;
                if (pendV) act <= pend;
            end
            // A load on the commit edge lands in pend after the old value moved to act.
            if (iLoad) begin
                pend  <= iData;
                pendV <= 1'b1;
            end else if (boundary) begin
                pendV <= 1'b0;
            end
        end
    end

    assign oSel     = digit;
    assign oBlank   = (state == IDLE);
    assign oPending = pendV;
    assign oNibble  = oBlank ? 4'd0 : act[{digit, 2'b00} +: 4];

endmodule

// File: doc/led_scan_ctrl.md
# led_scan_ctrl

Time-multiplexed scan controller for the 8-digit seven-segment display path. It holds a double-buffered 32-bit display value (one hex nibble per digit) and steps a digit index at a programmable dwell rate. Each cycle it drives the nibble/select pair consumed by the downstream digit decoder/selector (`iData[3:0]`, `iSel[2:0]`). Disabled digits are skipped; new values and masks take effect only at frame boundaries, so a frame never shows a mix of old and new data.

## Interface
- `DIV`, default 50000: dwell time per digit in `iClk` cycles; legal range ≥ 2. The prescaler width is derived internally.
- `iClk`  in  1  system clock; all state changes on the rising edge.
- `iRst_n`  in  1  reset, asynchronous, active-low.
- `iData`  in  32  new display value; nibble k = `iData[4k+3:4k]` shows on digit k.
- `iLoad`  in  1  single-cycle strobe that captures `iData` into the pending buffer.
- `iMask`  in  8  digit enable; bit k enables digit k; sampled only at a frame boundary.
- `oNibble`  out  4  nibble of the active buffer at the current digit; drives the decoder's `iData`.
- `oSel`  out  3  current digit index; drives the selector's `iSel`.
- `oBlank`  out  1  high while no digit is enabled; the board gates segments with it.
- `oPending`  out  1  high while a loaded value is waiting for commit.
- `oFrame`  out  1  one-cycle pulse on the cycle after a frame-boundary commit.

## Operation
- **Registers**
  - `pend[31:0]`, `pend_v`
  - `act[31:0]`
  - `mask_a[7:0]`
  - `digit[2:0]`
  - `presc`
  - state ∈ {RUN, IDLE}
- **Reset values**
  - `pend = 0`, `pend_v = 0`, `act = 0`.
  - `mask_a = 8'hFF`, `digit = 0`, `presc = 0`, state = RUN.
  - Outputs: `oNibble = 0`, `oSel = 0`, `oBlank = 0`, `oPending = 0`, `oFrame = 0`.
- **Prescaler**
  - `presc` counts 0..DIV-1 and wraps.
  - tick = (`presc == DIV-1`). The prescaler runs in both states.
- **Load**
  - `iLoad = 1` → `pend <= iData`, `pend_v <= 1`.
  - A repeated load before commit overwrites; the last load wins.
  - `oPending = pend_v`.
- **RUN, on tick**
  - If `digit` is not the highest set bit of `mask_a`: `digit <=` next higher set bit of `mask_a`.
  - Otherwise this is a frame boundary:
    - `mask_a <= iMask`.
    - If `pend_v`: `act <= pend` and `pend_v <= 0`.
    - `oFrame` pulses.
    - If `iMask != 0`: `digit <=` lowest set bit of `iMask`.
    - If `iMask == 0`: go to IDLE with `digit <= 0`.
- **IDLE**
  - `oBlank = 1`, `oSel = 0`, `oNibble = 0`.
  - On each tick, sample `iMask`. If nonzero, perform a boundary commit exactly as in RUN (commit pending, pulse `oFrame`), set `digit <=` lowest set bit of `iMask`, and go to RUN.
  - If still zero, stay in IDLE with no `oFrame`.
- **Output mapping**
  - `oSel = digit`.
  - `oNibble = act[4*digit +: 4]` (combinational from registers).
  - `oBlank = (state == IDLE)`.
- **Boundary cases**
  - `iMask` changes mid-frame: ignored until the boundary.
  - Single-bit mask: every tick is a boundary; `digit` is constant and `oFrame` pulses every DIV cycles.
  - `iLoad` in the same cycle as a boundary: `act` takes the old `pend`. The new data goes to `pend` with `pend_v = 1`, so `oPending` stays high.
  - `iLoad` with `pend_v = 0` in the boundary cycle: not committed this frame; commits at the next boundary.
  - `iRst_n` low mid-frame: all registers and outputs go to reset values immediately, with no clock edge needed. Scanning restarts at digit 0 with a fresh DIV dwell after release.

## Timing
- After reset release, digit 0 is shown for exactly DIV cycles.
- Each enabled digit dwells exactly DIV cycles; a frame with N enabled digits lasts N·DIV cycles.
- On a tick edge, `oSel`, `oNibble` (including new `act` data at a commit) and `oFrame` change on the same edge; `oFrame` is high for one cycle.
- Load-to-display latency is at most 8·DIV + 1 cycles with mask `FF`.
- `oPending` rises on the edge after `iLoad` and falls on the commit edge.
- IDLE exit: `oBlank` falls on the first tick edge at which `iMask != 0`.

## Test plan
All scenarios use DIV = 4.
1. Reset, `iMask = FF`, no load → `oSel` steps 0,1,…,7,0 every 4 cycles; `oNibble = 0`; `oFrame` pulses every 32 cycles; `oBlank = 0`.
2. Load `89ABCDEF` while `oSel = 3` → `oPending = 1`; digits 3–7 still show 0. At the boundary `oFrame = 1`, `oPending = 0`, then `oSel = 0` with `oNibble = F`, `oSel = 1` with `E`, …, `oSel = 7` with `8`.
3. Set `iMask = 81` mid-frame → the current frame completes 0–7; afterwards the sequence is 0,7,0,7 with a 4-cycle dwell and `oFrame` every 8 cycles.
4. Set `iMask = 00` → after the boundary `oBlank = 1`, `oSel = 0`, `oNibble = 0`, no `oFrame`. Then set `iMask = 04` → at the next tick `oBlank = 0`, `oSel = 2`, `oFrame` pulses.
5. Load `11111111` then `22222222` before the boundary → the frame shows `2` on all digits. A load of `33333333` coincident with the `oFrame` cycle → `oPending` stays 1, and `3`s appear one frame later.
6. Assert `iRst_n = 0` for 2 cycles mid-frame (`oSel = 5`, `act ≠ 0`) → outputs go to 0 asynchronously. After release `oSel = 0` for 4 cycles, `oNibble = 0`, `oPending = 0`.
